// File: rtl/cpu_dbg_pkg.sv
// Shared types and default constants for the cpu run/halt controller.
package cpu_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_STEP  = 3'd3,
        ST_DONE  = 3'd4
    } run_state_t;

    typedef enum logic [2:0] {
        STAT_NONE    = 3'd0,
        STAT_HALTED  = 3'd1,
        STAT_TIMEOUT = 3'd2,
        STAT_STUCK   = 3'd3,
        STAT_ABORT   = 3'd4
    } run_status_t;

    localparam int unsigned DEF_PC_W        = 64;
    localparam int unsigned DEF_CNT_W       = 32;
    localparam int unsigned DEF_MAX_CYCLES  = 200;
    localparam int unsigned DEF_TRACE_DEPTH = 16;
    localparam int unsigned DEF_STUCK_LIMIT = 8;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Control, core-side and observation signals of the run controller.
interface cpu_run_ctrl_if
    import cpu_dbg_pkg::*;
#(
    parameter int unsigned PC_W        = DEF_PC_W,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned TRACE_DEPTH = DEF_TRACE_DEPTH
) ();
    localparam int unsigned IDX_W = $clog2(TRACE_DEPTH);

    logic             start;
    logic             pause;
    logic             resume;
    logic             step;
    logic             abort;
    logic             cpu_halted;
    logic [PC_W-1:0]  cpu_pc;
    logic             pc_valid;
    logic             test_halt;
    logic             running;
    logic             done;
    logic [2:0]       status;
    logic [CNT_W-1:0] cycle_count;
    logic [PC_W-1:0]  final_pc;
    logic [IDX_W:0]   trace_count;
    logic [IDX_W-1:0] trace_rd_idx;
    logic [PC_W-1:0]  trace_rd_pc;

    modport master (
        output start, pause, resume, step, abort,
        output cpu_halted, cpu_pc, pc_valid, trace_rd_idx,
        input  test_halt, running, done, status, cycle_count,
        input  final_pc, trace_count, trace_rd_pc
    );

    modport slave (
        input  start, pause, resume, step, abort,
        input  cpu_halted, cpu_pc, pc_valid, trace_rd_idx,
        output test_halt, running, done, status, cycle_count,
        output final_pc, trace_count, trace_rd_pc
    );
endinterface

// File: rtl/pc_trace_buf.sv
// Circular buffer of the most recent retired PCs with a relative read port.
module pc_trace_buf #(
    parameter int unsigned PC_W  = 64,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [PC_W-1:0]  wr_pc,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [IDX_W:0]   count,
    output logic [PC_W-1:0]  rd_pc
);
    logic [PC_W-1:0]  mem [DEPTH];
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] rd_ptr;

    // Write pointer and saturating fill count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (clear) begin
                count <= '0;
            end else if (wr_en && (count != (IDX_W+1)'(DEPTH))) begin
                count <= count + 1'b1;
            end
        end
    end

    // Entry storage; unwritten entries are masked by count on read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_pc;
        end
    end

    // Index 0 is the newest entry; indices beyond the fill count read as zero.
    always_comb begin
        rd_ptr = wr_ptr - IDX_W'(1) - rd_idx;
        rd_pc  = '0;
        if ({1'b0, rd_idx} < count) begin
            rd_pc = mem[rd_ptr];
        end
    end
endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt controller: gates the core, terminates runs, records status and PC trace.
module cpu_run_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int unsigned PC_W        = DEF_PC_W,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned MAX_CYCLES  = DEF_MAX_CYCLES,
    parameter int unsigned TRACE_DEPTH = DEF_TRACE_DEPTH,
    parameter int unsigned STUCK_LIMIT = DEF_STUCK_LIMIT
) (
    input logic           clk,
    input logic           reset,
    cpu_run_ctrl_if.slave bus
);
    localparam int unsigned SW = $clog2(STUCK_LIMIT + 1);

    run_state_t       state, state_nxt;
    run_status_t      status, status_nxt;
    logic [CNT_W-1:0] cycle_count;
    logic [PC_W-1:0]  final_pc, final_nxt;
    logic [PC_W-1:0]  prev_pc;
    logic [SW-1:0]    stuck_cnt, stuck_nxt;
    logic             active, pc_hit, clear;
    logic             stuck_hit, timeout_hit;

    assign active = (state == ST_RUN) || (state == ST_STEP);
    assign pc_hit = active && bus.pc_valid;
    assign clear  = bus.start && ((state == ST_IDLE) || (state == ST_DONE));

    // Stuck run length including the current PC; a cleared counter restarts at 1
    // even if the PC matches the previous run's last PC.
    always_comb begin
        stuck_nxt = SW'(1);
        if ((stuck_cnt != '0) && (bus.cpu_pc == prev_pc)) begin
            stuck_nxt = stuck_cnt + 1'b1;
        end
        stuck_hit   = bus.pc_valid && (stuck_nxt == SW'(STUCK_LIMIT));
        timeout_hit = (cycle_count == CNT_W'(MAX_CYCLES - 1));
    end

    // Next state, latched status and final PC.
    always_comb begin
        state_nxt  = state;
        status_nxt = status;
        final_nxt  = final_pc;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_nxt  = ST_RUN;
                    status_nxt = STAT_NONE;
                end
            end
            ST_RUN, ST_STEP: begin
                if (bus.cpu_halted || bus.abort || stuck_hit || timeout_hit) begin
                    state_nxt = ST_DONE;
                    final_nxt = bus.pc_valid ? bus.cpu_pc : prev_pc;
                    if (bus.cpu_halted)  status_nxt = STAT_HALTED;
                    else if (bus.abort)  status_nxt = STAT_ABORT;
                    else if (stuck_hit)  status_nxt = STAT_STUCK;
                    else                 status_nxt = STAT_TIMEOUT;
                end else if ((state == ST_STEP) || bus.pause) begin
                    state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (bus.abort) begin
                    state_nxt  = ST_DONE;
                    status_nxt = STAT_ABORT;
                    final_nxt  = prev_pc;
                end else if (bus.resume) begin
                    state_nxt = ST_RUN;
                end else if (bus.step) begin
                    state_nxt = ST_STEP;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, status and run counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            status      <= STAT_NONE;
            final_pc    <= '0;
            cycle_count <= '0;
            stuck_cnt   <= '0;
            prev_pc     <= '0;
        end else begin
            state    <= state_nxt;
            status   <= status_nxt;
            final_pc <= final_nxt;
            if (clear) begin
                cycle_count <= '0;
                stuck_cnt   <= '0;
            end else begin
                if (active) cycle_count <= cycle_count + 1'b1;
                if (pc_hit) stuck_cnt <= stuck_nxt;
            end
            if (pc_hit) prev_pc <= bus.cpu_pc;
        end
    end

    pc_trace_buf #(
        .PC_W  (PC_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .wr_en  (pc_hit),
        .wr_pc  (bus.cpu_pc),
        .rd_idx (bus.trace_rd_idx),
        .count  (bus.trace_count),
        .rd_pc  (bus.trace_rd_pc)
    );

    assign bus.test_halt   = !active;
    assign bus.running     = active;
    assign bus.done        = (state == ST_DONE);
    assign bus.status      = status;
    assign bus.cycle_count = cycle_count;
    assign bus.final_pc    = final_pc;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl.
module tb_cpu_run_ctrl;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    cpu_run_ctrl_if #(.PC_W(64), .CNT_W(32), .TRACE_DEPTH(16)) bus ();

    cpu_run_ctrl #(
        .PC_W        (64),
        .CNT_W       (32),
        .MAX_CYCLES  (200),
        .TRACE_DEPTH (16),
        .STUCK_LIMIT (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start = 0; bus.pause = 0; bus.resume = 0; bus.step = 0; bus.abort = 0;
        bus.cpu_halted = 0; bus.cpu_pc = '0; bus.pc_valid = 0; bus.trace_rd_idx = '0;
    endtask

    task automatic do_start();
        bus.start = 1;
        tick();
        bus.start = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        clear_inputs();
        tick();
        tick();
        total++; if (bus.test_halt !== 1'b1) begin bad++; $display("FAIL reset_test_halt got=%0b want=1", bus.test_halt); end
        total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL reset_running got=%0b want=0", bus.running); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", bus.done); end
        total++; if (bus.status !== 3'd0) begin bad++; $display("FAIL reset_status got=%0d want=0", bus.status); end
        total++; if (bus.cycle_count !== 32'd0) begin bad++; $display("FAIL reset_cycle_count got=%0d want=0", bus.cycle_count); end
        total++; if (bus.trace_count !== 5'd0) begin bad++; $display("FAIL reset_trace_count got=%0d want=0", bus.trace_count); end
        reset = 0;
        tick();
        total++; if (bus.test_halt !== 1'b1) begin bad++; $display("FAIL idle_test_halt got=%0b want=1", bus.test_halt); end
    endtask

    task automatic test_halt_run();
        do_start();
        total++; if (bus.test_halt !== 1'b0 || bus.running !== 1'b1) begin bad++; $display("FAIL run_entry got test_halt=%0b running=%0b want 0/1", bus.test_halt, bus.running); end
        for (int i = 1; i <= 37; i++) begin
            bus.pc_valid = 1;
            bus.cpu_pc = 64'h1000 + 64'(4 * i);
            bus.cpu_halted = (i == 37);
            tick();
        end
        clear_inputs();
        total++; if (bus.done !== 1'b1 || bus.test_halt !== 1'b1 || bus.running !== 1'b0) begin bad++; $display("FAIL halt_state got done=%0b test_halt=%0b running=%0b want 1/1/0", bus.done, bus.test_halt, bus.running); end
        total++; if (bus.status !== 3'd1) begin bad++; $display("FAIL halt_status got=%0d want=1", bus.status); end
        total++; if (bus.cycle_count !== 32'd37) begin bad++; $display("FAIL halt_cycle_count got=%0d want=37", bus.cycle_count); end
        total++; if (bus.final_pc !== 64'h1094) begin bad++; $display("FAIL halt_final_pc got=%h want=1094", bus.final_pc); end
        total++; if (bus.trace_count !== 5'd16) begin bad++; $display("FAIL halt_trace_count got=%0d want=16", bus.trace_count); end
        bus.trace_rd_idx = 4'd3;
        #1;
        total++; if (bus.trace_rd_pc !== 64'h1088) begin bad++; $display("FAIL halt_trace_idx3 got=%h want=1088", bus.trace_rd_pc); end
        bus.trace_rd_idx = '0;
    endtask

    task automatic test_timeout();
        do_start();
        for (int i = 1; i <= 200; i++) begin
            bus.pc_valid = 1;
            bus.cpu_pc = 64'h2000 + 64'(4 * i);
            tick();
            if (i == 199) begin
                total++; if (bus.done !== 1'b0 || bus.cycle_count !== 32'd199) begin bad++; $display("FAIL timeout_early got done=%0b count=%0d want 0/199", bus.done, bus.cycle_count); end
            end
        end
        clear_inputs();
        tick();
        tick();
        total++; if (bus.done !== 1'b1 || bus.status !== 3'd2) begin bad++; $display("FAIL timeout_status got done=%0b status=%0d want 1/2", bus.done, bus.status); end
        total++; if (bus.cycle_count !== 32'd200) begin bad++; $display("FAIL timeout_cycle_count got=%0d want=200", bus.cycle_count); end
        total++; if (bus.trace_count !== 5'd16) begin bad++; $display("FAIL timeout_trace_count got=%0d want=16", bus.trace_count); end
        bus.trace_rd_idx = 4'd0;
        #1;
        total++; if (bus.trace_rd_pc !== 64'h2320) begin bad++; $display("FAIL timeout_trace_idx0 got=%h want=2320", bus.trace_rd_pc); end
        bus.trace_rd_idx = 4'd15;
        #1;
        total++; if (bus.trace_rd_pc !== 64'h2320 - 64'd60) begin bad++; $display("FAIL timeout_trace_idx15 got=%h want=22e4", bus.trace_rd_pc); end
        bus.trace_rd_idx = '0;
    endtask

    task automatic test_stuck();
        do_start();
        total++; if (bus.trace_count !== 5'd0 || bus.cycle_count !== 32'd0 || bus.status !== 3'd0) begin bad++; $display("FAIL restart_clear got trace=%0d count=%0d status=%0d want 0/0/0", bus.trace_count, bus.cycle_count, bus.status); end
        bus.pc_valid = 1;
        for (int i = 0; i < 7; i++) begin
            bus.cpu_pc = 64'h400;
            tick();
        end
        bus.cpu_pc = 64'h404;
        tick();
        total++; if (bus.done !== 1'b0 || bus.running !== 1'b1) begin bad++; $display("FAIL stuck_seven got done=%0b running=%0b want 0/1", bus.done, bus.running); end
        for (int i = 0; i < 8; i++) begin
            bus.cpu_pc = 64'h400;
            tick();
            if (i == 6) begin
                total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL stuck_early got done=%0b want=0", bus.done); end
            end
        end
        clear_inputs();
        total++; if (bus.done !== 1'b1 || bus.status !== 3'd3) begin bad++; $display("FAIL stuck_status got done=%0b status=%0d want 1/3", bus.done, bus.status); end
        total++; if (bus.final_pc !== 64'h400 || bus.cycle_count !== 32'd16) begin bad++; $display("FAIL stuck_final got pc=%h count=%0d want 400/16", bus.final_pc, bus.cycle_count); end
    endtask

    task automatic test_pause_step();
        do_start();
        for (int i = 1; i <= 10; i++) begin
            bus.pc_valid = 1;
            bus.cpu_pc = 64'h3000 + 64'(4 * i);
            bus.pause = (i == 10);
            tick();
        end
        bus.pause = 0;
        total++; if (bus.test_halt !== 1'b1 || bus.cycle_count !== 32'd10) begin bad++; $display("FAIL pause_entry got test_halt=%0b count=%0d want 1/10", bus.test_halt, bus.cycle_count); end
        bus.cpu_pc = 64'hdead;
        bus.cpu_halted = 1;
        tick();
        tick();
        total++; if (bus.done !== 1'b0 || bus.cycle_count !== 32'd10 || bus.trace_count !== 5'd10) begin bad++; $display("FAIL pause_hold got done=%0b count=%0d trace=%0d want 0/10/10", bus.done, bus.cycle_count, bus.trace_count); end
        bus.cpu_halted = 0;
        for (int k = 0; k < 3; k++) begin
            bus.step = 1;
            bus.pc_valid = 0;
            tick();
            bus.step = 0;
            total++; if (bus.test_halt !== 1'b0) begin bad++; $display("FAIL step%0d_open got test_halt=%0b want=0", k, bus.test_halt); end
            bus.pc_valid = 1;
            bus.cpu_pc = 64'h3100 + 64'(4 * k);
            tick();
            bus.pc_valid = 0;
            total++; if (bus.test_halt !== 1'b1 || bus.cycle_count !== 32'(11 + k)) begin bad++; $display("FAIL step%0d_close got test_halt=%0b count=%0d want 1/%0d", k, bus.test_halt, bus.cycle_count, 11 + k); end
        end
        bus.step = 1;
        bus.resume = 1;
        tick();
        bus.step = 0;
        bus.resume = 0;
        tick();
        total++; if (bus.test_halt !== 1'b0 || bus.cycle_count !== 32'd14) begin bad++; $display("FAIL resume_wins got test_halt=%0b count=%0d want 0/14", bus.test_halt, bus.cycle_count); end
        bus.start = 1;
        bus.pause = 1;
        tick();
        bus.start = 0;
        bus.pause = 0;
        total++; if (bus.test_halt !== 1'b1 || bus.cycle_count !== 32'd15) begin bad++; $display("FAIL start_ignored got test_halt=%0b count=%0d want 1/15", bus.test_halt, bus.cycle_count); end
        bus.abort = 1;
        tick();
        bus.abort = 0;
        total++; if (bus.done !== 1'b1 || bus.status !== 3'd4) begin bad++; $display("FAIL pause_abort got done=%0b status=%0d want 1/4", bus.done, bus.status); end
        total++; if (bus.final_pc !== 64'h3108 || bus.cycle_count !== 32'd15) begin bad++; $display("FAIL pause_abort_final got pc=%h count=%0d want 3108/15", bus.final_pc, bus.cycle_count); end
    endtask

    task automatic test_priority();
        do_start();
        for (int i = 1; i <= 4; i++) begin
            bus.pc_valid = 1;
            bus.cpu_pc = 64'h5000 + 64'(i);
            bus.cpu_halted = (i == 4);
            bus.abort = (i == 4);
            tick();
        end
        clear_inputs();
        total++; if (bus.status !== 3'd1 || bus.cycle_count !== 32'd4 || bus.final_pc !== 64'h5004) begin bad++; $display("FAIL halt_over_abort got status=%0d count=%0d pc=%h want 1/4/5004", bus.status, bus.cycle_count, bus.final_pc); end
    endtask

    task automatic test_reset_midrun();
        do_start();
        for (int i = 1; i <= 50; i++) begin
            bus.pc_valid = 1;
            bus.cpu_pc = 64'h6000 + 64'(4 * i);
            tick();
        end
        #2 reset = 1;
        #1;
        total++; if (bus.test_halt !== 1'b1 || bus.running !== 1'b0 || bus.done !== 1'b0 || bus.status !== 3'd0) begin bad++; $display("FAIL async_reset_ctrl got th=%0b run=%0b done=%0b st=%0d want 1/0/0/0", bus.test_halt, bus.running, bus.done, bus.status); end
        total++; if (bus.cycle_count !== 32'd0 || bus.final_pc !== 64'd0 || bus.trace_count !== 5'd0 || bus.trace_rd_pc !== 64'd0) begin bad++; $display("FAIL async_reset_data got count=%0d pc=%h trace=%0d rd=%h want zeros", bus.cycle_count, bus.final_pc, bus.trace_count, bus.trace_rd_pc); end
        clear_inputs();
        tick();
        reset = 0;
        tick();
        do_start();
        total++; if (bus.cycle_count !== 32'd0 || bus.running !== 1'b1) begin bad++; $display("FAIL clean_start got count=%0d running=%0b want 0/1", bus.cycle_count, bus.running); end
        for (int i = 1; i <= 5; i++) begin
            bus.pc_valid = 1;
            bus.cpu_pc = 64'h7000 + 64'(4 * i);
            tick();
        end
        total++; if (bus.cycle_count !== 32'd5 || bus.trace_count !== 5'd5 || bus.trace_rd_pc !== 64'h7014) begin bad++; $display("FAIL clean_run got count=%0d trace=%0d rd=%h want 5/5/7014", bus.cycle_count, bus.trace_count, bus.trace_rd_pc); end
        clear_inputs();
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1;
        test_reset();
        test_halt_run();
        test_timeout();
        test_stuck();
        test_pause_step();
        test_priority();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Synthesizable run/halt controller for the ARMv8 core, parametrised successor to the fixed 200-cycle bench sequence. It gates the core through its test_halt input and supports free run, pause and single-step. It terminates a run on core halt, cycle budget, stuck PC or abort, and latches a status code, cycle count and final PC. It also keeps a circular trace of the most recent retired PCs. It sits between the bench (or a later debug port) and the cpu top.

Parameters:
PC_W, 64, width of program counter
CNT_W, 32, width of cycle counter
MAX_CYCLES, 200, run-cycle budget before TIMEOUT (1..2^CNT_W-1)
TRACE_DEPTH, 16, PC trace entries (power of two, >=2)
STUCK_LIMIT, 8, consecutive identical valid PCs that declare STUCK (>=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  pulse: begin run (accepted in IDLE or DONE only)
pause  in  1  pulse: RUN -> PAUSE
resume  in  1  pulse: PAUSE -> RUN
step  in  1  pulse: in PAUSE, run exactly one cycle
abort  in  1  pulse: end run with ABORT
cpu_halted  in  1  core halted flag
cpu_pc  in  PC_W  core PC
pc_valid  in  1  cpu_pc is a retired PC this cycle
test_halt  out  1  to core; 1 = core frozen
running  out  1  1 in RUN or STEP
done  out  1  1 in DONE
status  out  3  0 NONE, 1 HALTED, 2 TIMEOUT, 3 STUCK, 4 ABORT
cycle_count  out  CNT_W  active cycles in current/last run
final_pc  out  PC_W  last valid PC when DONE was entered
trace_count  out  $clog2(TRACE_DEPTH)+1  valid trace entries
trace_rd_idx  in  $clog2(TRACE_DEPTH)  0 = most recent
trace_rd_pc  out  PC_W  combinational trace read

Behaviour:
- Reset (asynchronous): state IDLE, test_halt=1, running=0, done=0, status=0, cycle_count=0, final_pc=0, trace_count=0, stuck counter=0, previous-PC register=0.
- States: IDLE, RUN, PAUSE, STEP, DONE. test_halt = !(state==RUN || state==STEP), decoded from the state register only (no input-to-output path).
- IDLE/DONE + start: next state RUN. cycle_count, trace_count, stuck counter, status and done all clear on the same edge.
- Active cycle = cycle in RUN or STEP. On each active cycle cycle_count increments by 1. Inputs are sampled only on active cycles; pc_valid in other states is ignored.
- Trace: on an active cycle with pc_valid, cpu_pc is written at the write pointer and the pointer increments modulo TRACE_DEPTH. The oldest entry is overwritten when full. trace_count saturates at TRACE_DEPTH.
- trace_rd_pc = entry (wr_ptr-1-trace_rd_idx) mod DEPTH. It returns 0 when trace_rd_idx >= trace_count.
- Stuck detection: on a valid PC equal to the previous valid PC, the stuck counter increments; otherwise it resets to 1. The first valid PC of a run counts 1. STUCK fires when the counter reaches STUCK_LIMIT.
- Termination is evaluated on active cycles. Priority: cpu_halted > abort > STUCK > TIMEOUT. TIMEOUT fires on the active cycle where cycle_count becomes MAX_CYCLES.
- On termination: next state DONE, status latched, final_pc = the current cpu_pc if pc_valid, else the last valid PC.
- abort is also honoured in PAUSE (-> DONE, ABORT). cpu_halted seen in PAUSE is not acted on until the next active cycle.
- RUN + pause (no termination): -> PAUSE. The core is frozen from the next cycle.
- PAUSE + resume -> RUN. PAUSE + step -> STEP. STEP always returns to PAUSE after 1 cycle unless it terminates.
- In PAUSE, if step and resume are both asserted, resume wins. start in RUN/PAUSE/STEP is ignored.
- DONE holds all outputs until start or reset. Reset mid-run returns to IDLE immediately with all outputs cleared.

Decomposition:
- Shared package cpu_dbg_pkg holds:
  - run_state_t enum (IDLE, RUN, PAUSE, STEP, DONE);
  - run_status_t enum with the 3-bit encodings above;
  - the default parameter constants.
- One sub-module, pc_trace_buf, is natural: circular buffer with write pointer, saturating count, and relative-index read port.

Test Plan:
- Free run with core asserting cpu_halted at active cycle 37 -> DONE, status=1, cycle_count=37, final_pc = PC on that cycle, test_halt=1 the following cycle.
- MAX_CYCLES=200, never halts, PCs incrementing by 4 -> status=2, cycle_count=200, trace_count=16, trace_rd_idx=0 returns last PC, idx 15 returns last-60.
- PC repeats 0x400 for 8 consecutive valid cycles -> status=3, final_pc=0x400. A sequence of 7 repeats then 0x404 does not terminate.
- pause at cycle 10, 3 step pulses, then resume -> cycle_count advances exactly 1 per step, test_halt low for exactly one cycle per step.
- abort in PAUSE -> status=4. Same-cycle cpu_halted and abort in RUN -> status=1.
- Assert reset mid-RUN at cycle 50 -> all outputs return to reset values asynchronously. start afterwards begins a clean run with cycle_count from 0.
